gpio_edge_irq: RTL and testbench
================================

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

Interface
REQ-001 Parameter W, default 8: number of input pins handled.
REQ-002 Parameter DEB_CNT, default 4: consecutive stable synchronized cycles required to accept a pin change; legal range 1..255.
REQ-003 PCLK  input  1  APB clock; all state on rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-high.
REQ-005 PADDR  input  4  byte address; PADDR[3:2] selects register.
REQ-006 PWRITE  input  1  1=write, 0=read.
REQ-007 PENABLE  input  1  APB access phase.
REQ-008 PWDATA  input  32  write data.
REQ-009 PSEL  input  1  slave select.
REQ-010 PRDATA  output  32  read data, registered.
REQ-011 PREADY  output  1  transfer complete, registered.
REQ-012 pin_in  input  W  raw asynchronous pad inputs.
REQ-013 din  output  W  synchronized, debounced pin values; feeds GPIO input data register.
REQ-014 irq  output  1  level interrupt to CPU.

Function
REQ-015 Register map (bits [W-1:0] used, upper bits read 0, write-ignored): 0x0 IER rw; 0x4 RISE rw; 0x8 FALL rw; 0xC ISR read / write-1-to-clear.
REQ-016 APB: when PSEL&&PENABLE&&!PREADY, PREADY SHALL be 1 in the next cycle; PREADY SHALL be 0 in all other cycles (one-cycle pulse, one wait state per access).
REQ-017 Write data SHALL update the addressed register on the same edge that raises PREADY; PRDATA SHALL be loaded on that edge and hold its value until the next read.
REQ-018 Each pin_in[i] SHALL pass a 2-flop synchronizer producing s[i].
REQ-019 Per bit: s==din: counter<=0; s!=din and counter==DEB_CNT-1: din<=s, counter<=0; else counter++.
REQ-020 Latency: a pin held stable after a change SHALL appear on din exactly 2+DEB_CNT cycles after the first sampling edge.
REQ-021 Glitches shorter than DEB_CNT synchronized cycles SHALL NOT change din (counter restarts at 0).
REQ-022 On the edge where din[i] changes 0->1 with RISE[i]=1, or 1->0 with FALL[i]=1, ISR[i] SHALL become 1.
REQ-023 ISR SHALL be set independent of IER; IER only gates irq.
REQ-024 Simultaneous set event and W1C clear on the same bit: set wins, ISR bit stays 1.
REQ-025 irq SHALL equal |(ISR & IER), derived from registered state only (no combinational path from APB inputs).
REQ-026 Writing 0 bits to ISR SHALL leave them unchanged.

Reset
REQ-027 PRESET high SHALL asynchronously clear IER, RISE, FALL, ISR, synchronizers, counters, din, PRDATA, PREADY to 0; hence irq=0.
REQ-028 Reset mid-transfer SHALL abort it; no register write completes; first access after release behaves as REQ-016.
REQ-029 After reset release, a pin held at 1 SHALL produce a din 0->1 transition per REQ-020 and set ISR only if RISE was enabled by then.

Structure
REQ-030 Package gpio_edge_irq_pkg SHALL hold register offset constants (IER, RISE, FALL, ISR) and the DEB_CNT default.
REQ-031 Sub-module gpio_in_filter (synchronizer + debounce counter + edge outputs, one bit) SHALL be instantiated W times via generate.

Verification
REQ-032 Reset, read 0x0/0x4/0x8/0xC -> all return 0x00000000, irq=0, PREADY pulses once per access.
REQ-033 Write RISE=0x01, IER=0x01; pin_in[0] 0->1 held -> din[0]=1 after 6 cycles (DEB_CNT=4), ISR=0x01, irq=1.
REQ-034 pin_in[1] 3-cycle pulse with RISE=FALL=0x02 -> din[1] stays 0, ISR=0x00.
REQ-035 ISR=0x01, write 0xC=0x01 -> ISR=0x00, irq=0; write 0xC=0x00 with ISR=0x03 -> ISR stays 0x03.
REQ-036 W1C to bit 2 on the same edge din[2] falls with FALL=0x04 -> ISR[2]=1.
REQ-037 IER=0x00 with ISR=0x80 -> irq=0; then IER=0x80 -> irq=1 the cycle after write completes.

Source files
------------

// File: rtl/gpio_edge_irq_pkg.sv
// GPIO edge interrupt: shared constants.
// Register offsets and debounce default.
package gpio_edge_irq_pkg;

  localparam logic [3:0] IER_OFF  = 4'h0;
  localparam logic [3:0] RISE_OFF = 4'h4;
  localparam logic [3:0] FALL_OFF = 4'h8;
  localparam logic [3:0] ISR_OFF  = 4'hC;

  localparam logic [1:0] IDX_IER  = IER_OFF[3:2];
  localparam logic [1:0] IDX_RISE = RISE_OFF[3:2];
  localparam logic [1:0] IDX_FALL = FALL_OFF[3:2];
  localparam logic [1:0] IDX_ISR  = ISR_OFF[3:2];

  localparam int DEB_CNT_DEF = 4;

endpackage

// File: rtl/gpio_in_filter.sv
// One pin: 2-flop synchronizer, debounce
// counter and edge strobes for din changes.
module gpio_in_filter #(
  parameter int DEB_CNT = 4
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic pin_in,
  output logic din,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(DEB_CNT - 1);

  logic       sync1_q, sync1_d;
  logic       s_q, s_d;
  logic       din_q, din_d;
  logic [7:0] cnt_q, cnt_d;

  // Accept s only after it disagrees with din for DEB_CNT edges.
  always_comb begin
    sync1_d = pin_in;
    s_d     = sync1_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    if (s_q == din_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      din_d = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = 8'(cnt_q + 8'd1);
    end
  end

  // Synchronizer, filtered value and counter state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      din_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign din  = din_q;
  assign rise = din_d & ~din_q;
  assign fall = ~din_d & din_q;

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO edge interrupt block with APB regs:
// IER, RISE, FALL and W1C status ISR.
module gpio_edge_irq
  import gpio_edge_irq_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic [3:0]    PADDR,
  input  logic          PWRITE,
  input  logic          PENABLE,
  input  logic [31:0]   PWDATA,
  input  logic          PSEL,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  input  logic [W-1:0]  pin_in,
  output logic [W-1:0]  din,
  output logic          irq
);

  logic [W-1:0] rise_ev, fall_ev;

  logic [W-1:0] ier_q, ier_d;
  logic [W-1:0] rise_en_q, rise_en_d;
  logic [W-1:0] fall_en_q, fall_en_d;
  logic [W-1:0] isr_q, isr_d;
  logic [31:0]  prdata_q, prdata_d;
  logic         pready_q, pready_d;

  logic         acc, wr, rd;
  logic [W-1:0] clr, set;
  logic [W-1:0] wdat;
  logic         unused_ok;

  for (genvar i = 0; i < W; i++) begin : g_pin
    gpio_in_filter #(
      .DEB_CNT(DEB_CNT)
    ) u_filt (
      .PCLK  (PCLK),
      .PRESET(PRESET),
      .pin_in(pin_in[i]),
      .din   (din[i]),
      .rise  (rise_ev[i]),
      .fall  (fall_ev[i])
    );
  end

  assign acc  = PSEL & PENABLE & ~pready_q;
  assign wr   = acc & PWRITE;
  assign rd   = acc & ~PWRITE;
  assign wdat = PWDATA[W-1:0];
  assign set  = (rise_ev & rise_en_q)
              | (fall_ev & fall_en_q);

  assign unused_ok = ^{PADDR[1:0], PWDATA};

  // Register writes, W1C with set priority, read capture.
  always_comb begin
    ier_d     = ier_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    prdata_d  = prdata_q;
    pready_d  = acc;
    if (wr) begin
      unique case (PADDR[3:2])
        IDX_IER:  ier_d     = wdat;
        IDX_RISE: rise_en_d = wdat;
        IDX_FALL: fall_en_d = wdat;
        IDX_ISR:  clr       = wdat;
        default:  clr       = '0;
      endcase
    end
    if (rd) begin
      prdata_d = '0;
      unique case (PADDR[3:2])
        IDX_IER:  prdata_d[W-1:0] = ier_q;
        IDX_RISE: prdata_d[W-1:0] = rise_en_q;
        IDX_FALL: prdata_d[W-1:0] = fall_en_q;
        IDX_ISR:  prdata_d[W-1:0] = isr_q;
        default:  prdata_d = '0;
      endcase
    end
    isr_d = (isr_q & ~clr) | set;
  end

  // Register file and APB response state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ier_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      isr_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
    end else begin
      ier_q     <= ier_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      isr_q     <= isr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
    end
  end

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign irq    = |(isr_q & ier_q);

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Bench for gpio_edge_irq: directed scenarios
// plus random pins/APB against a window model.
module tb_gpio_edge_irq;

  localparam int W   = 8;
  localparam int DEB = 4;

  logic          PCLK;
  logic          PRESET;
  logic [3:0]    PADDR;
  logic          PWRITE;
  logic          PENABLE;
  logic [31:0]   PWDATA;
  logic          PSEL;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic [W-1:0]  pin_in;
  logic [W-1:0]  din;
  logic          irq;

  int n_cmp;
  int n_bad;

  gpio_edge_irq #(
    .W      (W),
    .DEB_CNT(DEB)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PENABLE(PENABLE),
    .PWDATA (PWDATA),
    .PSEL   (PSEL),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .pin_in (pin_in),
    .din    (din),
    .irq    (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Reference model: din flips once the last DEB
  // synchronized samples all disagree with it.
  logic [W-1:0] m_ier, m_rise, m_fall, m_isr;
  logic [W-1:0] m_din, m_s1, m_s2;
  logic [W-1:0] m_win [DEB];
  logic         m_ready;
  logic [31:0]  m_prdata;
  logic         m_irq;

  assign m_irq = |(m_isr & m_ier);

  always @(posedge PCLK or posedge PRESET) begin : model
    logic [W-1:0] nd, clr, rv, setv;
    logic         acc, run;
    if (PRESET) begin
      m_ier    <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_isr    <= '0;
      m_din    <= '0;
      m_s1     <= '0;
      m_s2     <= '0;
      m_ready  <= 1'b0;
      m_prdata <= '0;
      for (int j = 0; j < DEB; j++) m_win[j] <= '0;
    end else begin
      nd = m_din;
      for (int i = 0; i < W; i++) begin
        run = (m_s2[i] != m_din[i]);
        for (int j = 0; j < DEB - 1; j++)
          if (m_win[j][i] == m_din[i]) run = 1'b0;
        if (run) nd[i] = ~m_din[i];
      end
      setv = (nd & ~m_din & m_rise)
           | (~nd & m_din & m_fall);
      acc = PSEL && PENABLE && !m_ready;
      clr = '0;
      rv  = '0;
      if (acc && PWRITE) begin
        case (PADDR[3:2])
          2'd0: m_ier  <= PWDATA[W-1:0];
          2'd1: m_rise <= PWDATA[W-1:0];
          2'd2: m_fall <= PWDATA[W-1:0];
          default: clr = PWDATA[W-1:0];
        endcase
      end
      if (acc && !PWRITE) begin
        case (PADDR[3:2])
          2'd0: rv = m_ier;
          2'd1: rv = m_rise;
          2'd2: rv = m_fall;
          default: rv = m_isr;
        endcase
        m_prdata <= 32'(rv);
      end
      m_isr   <= (m_isr & ~clr) | setv;
      m_ready <= acc;
      m_din   <= nd;
      m_win[0] <= m_s2;
      for (int j = 1; j < DEB; j++)
        m_win[j] <= m_win[j-1];
      m_s2 <= m_s1;
      m_s1 <= pin_in;
    end
  end

  task automatic apb(input logic [3:0] a,
                     input logic wr,
                     input logic [31:0] wd,
                     output logic [31:0] rdv,
                     output int lat);
    @(posedge PCLK); #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PADDR   = a;
    PWRITE  = wr;
    PWDATA  = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 0;
    do begin
      @(posedge PCLK); #1;
      lat++;
    end while (!PREADY && lat < 8);
    n_cmp++;
    if (PREADY !== 1'b1) begin
      n_bad++;
      $display("FAIL apb_timeout got %b want 1", PREADY);
    end
    rdv = PRDATA;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a,
                        input logic [31:0] d);
    logic [31:0] r;
    int l;
    apb(a, 1'b1, d, r, l);
  endtask

  task automatic rd_reg(input logic [3:0] a,
                        output logic [31:0] r);
    int l;
    apb(a, 1'b0, 32'h0, r, l);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int l;
    PRESET  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    pin_in  = '0;
    repeat (3) @(posedge PCLK);
    #1;
    n_cmp++;
    if ({PREADY, irq, din, PRDATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got %h/%b/%b want 0",
               PRDATA, PREADY, irq);
    end
    PRESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apb(4'(k * 4), 1'b0, 32'h0, r, l);
      n_cmp++;
      if (r !== 32'h0 || l != 1) begin
        n_bad++;
        $display("FAIL reset_read%0d got %h lat %0d want 0 lat 1",
                 k, r, l);
      end
      @(posedge PCLK); #1;
      n_cmp++;
      if (PREADY !== 1'b0 || irq !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_pulse%0d got %b irq %b want 0",
                 k, PREADY, irq);
      end
    end
  endtask

  task automatic test_rise_irq;
    logic [31:0] r;
    wr_reg(4'h4, 32'h01);
    wr_reg(4'h0, 32'h01);
    pin_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge PCLK); #1;
      if (k == 5) begin
        n_cmp++;
        if (din[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL rise_early got %b want 0", din[0]);
        end
      end
    end
    n_cmp++;
    if (din[0] !== 1'b1 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL rise_lat din %b irq %b want 1 1",
               din[0], irq);
    end
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h01) begin
      n_bad++;
      $display("FAIL rise_isr got %h want 01", r);
    end
  endtask

  task automatic test_w1c_clear;
    logic [31:0] r;
    wr_reg(4'hC, 32'h01);
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL w1c_clear got %h irq %b want 0 0", r, irq);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] r;
    logic bad;
    wr_reg(4'h8, 32'h02);
    wr_reg(4'h4, 32'h03);
    pin_in[1] = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    pin_in[1] = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(posedge PCLK); #1;
      if (din[1] !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL glitch_din got 1 want 0");
    end
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_bad++;
      $display("FAIL glitch_isr got %h want 0", r);
    end
  endtask

  task automatic test_w1c_zero;
    logic [31:0] r;
    wr_reg(4'h8, 32'h03);
    pin_in[0] = 1'b0;
    pin_in[1] = 1'b1;
    repeat (8) @(posedge PCLK);
    #1;
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h03) begin
      n_bad++;
      $display("FAIL both_edges got %h want 03", r);
    end
    wr_reg(4'hC, 32'h00);
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h03 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL w1c_zero got %h irq %b want 03 1",
               r, irq);
    end
    wr_reg(4'hC, 32'h03);
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_bad++;
      $display("FAIL w1c_both got %h want 0", r);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] r;
    wr_reg(4'h8, 32'h04);
    pin_in[2] = 1'b1;
    repeat (8) @(posedge PCLK);
    @(posedge PCLK); #1;
    pin_in[2] = 1'b0;
    repeat (3) @(posedge PCLK);
    wr_reg(4'hC, 32'h04);
    n_cmp++;
    if (din[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL setwin_din got %b want 0", din[2]);
    end
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h04) begin
      n_bad++;
      $display("FAIL set_wins got %h want 04", r);
    end
    wr_reg(4'hC, 32'hFF);
  endtask

  task automatic test_ier_gate;
    logic [31:0] r;
    wr_reg(4'h0, 32'h00);
    wr_reg(4'h4, 32'h80);
    pin_in[7] = 1'b1;
    repeat (8) @(posedge PCLK);
    #1;
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h80 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL ier_off got %h irq %b want 80 0", r, irq);
    end
    wr_reg(4'h0, 32'h80);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL ier_on got %b want 1", irq);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int l;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = 4'h0; PWRITE = 1'b1; PWDATA = 32'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PRESET  = 1'b1;
    #1;
    n_cmp++;
    if ({PREADY, irq, din} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got %b %b %h want 0",
               PREADY, irq, din);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge PCLK); #1;
      if (k == 5) begin
        n_cmp++;
        if (din !== 8'h00) begin
          n_bad++;
          $display("FAIL post_rst_early got %h want 00", din);
        end
      end
    end
    n_cmp++;
    if (din !== 8'h82) begin
      n_bad++;
      $display("FAIL post_rst_din got %h want 82", din);
    end
    apb(4'h0, 1'b0, 32'h0, r, l);
    n_cmp++;
    if (r !== 32'h0 || l != 1) begin
      n_bad++;
      $display("FAIL mid_ier got %h lat %0d want 0 lat 1", r, l);
    end
    rd_reg(4'hC, r);
    n_cmp++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst_isr got %h want 0", r);
    end
  endtask

  task automatic test_random;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    pin_in = 8'($urandom);
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    fork
      begin : pins
        for (int c = 0; c < 600; c++) begin
          @(posedge PCLK); #1;
          if ($urandom_range(0, 4) == 0)
            pin_in = pin_in ^ 8'($urandom & $urandom);
        end
      end
      begin : bus
        logic [31:0] r;
        int l;
        for (int t = 0; t < 70; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge PCLK);
          apb(4'($urandom), 1'($urandom),
              $urandom, r, l);
        end
      end
      begin : chk
        for (int c = 0; c < 600; c++) begin
          @(negedge PCLK);
          n_cmp++;
          if (din !== m_din || irq !== m_irq ||
              PREADY !== m_ready || PRDATA !== m_prdata) begin
            n_bad++;
            $display("FAIL rand_c%0d got %h %b %b %h want %h %b %b %h",
                     c, din, irq, PREADY, PRDATA,
                     m_din, m_irq, m_ready, m_prdata);
          end
        end
      end
    join
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_rise_irq();
    test_w1c_clear();
    test_glitch();
    test_w1c_zero();
    test_set_wins();
    test_ier_gate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
